// File: rtl/divider_pkg.sv
// divider_pkg: shared width, iteration count, state encoding and div-by-zero constant.
package divider_pkg;
  localparam int WIDTH = 16;
  localparam int ITER = WIDTH;
  localparam logic [WIDTH-1:0] DBZ_QUOT = '1;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_e;
endpackage

// File: rtl/div_step_16bit.sv
// div_step_16bit: one combinational restoring-division step.
module div_step_16bit
  import divider_pkg::*;
(
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, trial;
  assign shifted = {partial_rem, dividend_bit};
  assign trial = shifted - {1'b0, divisor};
  // partial_rem < divisor keeps the restored value within WIDTH bits
  assign q_bit = ~trial[WIDTH];
  assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/divider_16bit.sv
// divider_16bit: sequential unsigned restoring divider, one quotient bit per clock.
module divider_16bit
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             parity_check
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
  logic [4:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d, par_q, par_d;
  logic [WIDTH-1:0] next_rem;
  logic q_bit;

  div_step_16bit u_step (
    .partial_rem (rem_q),
    .dividend_bit(dvd_q[WIDTH-1]),
    .divisor     (dvs_q),
    .next_rem    (next_rem),
    .q_bit       (q_bit)
  );

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    state_d = state_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    quot_d = quot_q;
    remo_d = remo_q;
    dbz_d = dbz_q;
    par_d = par_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? LOAD : IDLE;
        if (start) begin
          dvd_d = A;
          dvs_d = B;
          rem_d = '0;
          cnt_d = '0;
        end
      end
      LOAD: begin
        state_d = (dvs_q == '0) ? DONE : CALC;
        if (dvs_q == '0) begin
          quot_d = DBZ_QUOT;
          remo_d = dvd_q;
          dbz_d = 1'b1;
          par_d = ^{DBZ_QUOT, dvd_q};
        end
      end
      CALC: begin
        dvd_d = {dvd_q[WIDTH-2:0], q_bit};
        rem_d = next_rem;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) begin
          state_d = DONE;
          quot_d = dvd_d;
          remo_d = next_rem;
          dbz_d = 1'b0;
          par_d = ^{dvd_d, next_rem};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      quot_q <= '0;
      remo_q <= '0;
      dbz_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      dbz_q <= dbz_d;
      par_q <= par_d;
    end
  end

  assign busy = (state_q == LOAD) || (state_q == CALC);
  assign done = (state_q == DONE);
  assign quotient = quot_q;
  assign remainder = remo_q;
  assign div_by_zero = dbz_q;
  assign parity_check = par_q;
endmodule
